// File: rtl/mips32_pkg.sv
// Shared widths and enumerations for the mips32 memory subsystem.
package mips32_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

endpackage

// File: rtl/mips32_lat_timer.sv
// Loadable down-counter that tracks the memory read latency.
// o_done is high for the single cycle in which mem_rdata is valid.
module mips32_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_done
);

  localparam int                CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Loaded at the grant edge, so a count of one marks grant + MEM_LAT.
  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and
// data memory: DM priority, IF starvation guard, squash of stale IF reads.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int                 WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            r_state;
  owner_e            r_owner;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_squash;
  logic              r_rvalid_q;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_idle;
  logic w_if_starved;
  logic w_if_gnt;
  logic w_dm_gnt;
  logic w_rd_gnt;
  logic w_done;

  // Grants are combinational; qualifying with rst_n keeps them quiet while in reset.
  assign w_idle       = (r_state == IDLE) && rst_n;
  assign w_if_starved = (r_wait_cnt == WAIT_MAX);
  assign w_dm_gnt     = w_idle && dm_req && !(if_req && w_if_starved);
  assign w_if_gnt     = w_idle && if_req && !w_dm_gnt;
  assign w_rd_gnt     = w_if_gnt || (w_dm_gnt && !dm_we);

  mips32_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_rd_gnt),
    .o_done (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= OWN_NONE;
      r_wait_cnt <= '0;
      r_squash   <= 1'b0;
      r_rvalid_q <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_rvalid_q <= 1'b0;

      if (!if_req || w_if_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_rd_gnt) begin
            r_state  <= RD_WAIT;
            r_owner  <= w_if_gnt ? OWN_IF : OWN_DM;
            r_squash <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (if_flush && (r_owner == OWN_IF)) begin
            r_squash <= 1'b1;
          end
          if (w_done) begin
            r_state    <= IDLE;
            r_rvalid_q <= 1'b1;
            // A squashed fetch never delivers, so its data must not disturb if_rdata.
            if (r_owner == OWN_DM) begin
              r_dm_rdata <= mem_rdata;
            end else if (!r_squash && !if_flush) begin
              r_if_rdata <= mem_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign mem_en    = w_if_gnt || w_dm_gnt;
  assign mem_we    = w_dm_gnt && dm_we;
  assign mem_addr  = w_dm_gnt ? dm_addr : (w_if_gnt ? if_addr : '0);
  assign mem_wdata = w_dm_gnt ? dm_wdata : '0;

  assign busy      = (r_state == RD_WAIT);
  assign if_rvalid = r_rvalid_q && (r_owner == OWN_IF) && !r_squash && !if_flush;
  assign dm_rvalid = r_rvalid_q && (r_owner == OWN_DM);
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: stimulus pushes expected read
// returns into queues, a negedge monitor pops and compares them.
module tb_mips32_mem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MEM_LAT  = 1;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_flush = 1'b0;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  logic [DATA_W-1:0] mem [1024];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t if_q[$];
  exp_t dm_q[$];
  exp_t mon_e;

  mips32_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_LAT  (MEM_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with one cycle of read latency; idle cycles drive a poison value.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    else                   mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_dm, output int t);
    bit found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if ((is_dm ? dm_gnt : if_gnt) === 1'b1) begin
        found = 1'b1;
        t = cyc;
      end else begin
        tick();
      end
    end
    check(is_dm ? "dm_gnt_timeout" : "if_gnt_timeout", {63'b0, found}, 64'd1);
  endtask

  task automatic dm_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    int t;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = a;
    wait_gnt(1'b1, t);
    dm_q.push_back('{exp, t + 2});
    tick();
    dm_req = 1'b0;
  endtask

  task automatic if_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    int t;
    if_req = 1'b1; if_addr = a;
    wait_gnt(1'b0, t);
    if_q.push_back('{exp, t + 2});
    tick();
    if_req = 1'b0;
  endtask

  // Monitor: every rvalid must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        check("if_rvalid_unexpected", {63'b0, if_rvalid}, 64'd0);
      end else begin
        mon_e = if_q.pop_front();
        check("if_rdata", {32'b0, if_rdata}, {32'b0, mon_e.data});
        check("if_rvalid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (dm_rvalid) begin
      if (dm_q.size() == 0) begin
        check("dm_rvalid_unexpected", {63'b0, dm_rvalid}, 64'd0);
      end else begin
        mon_e = dm_q.pop_front();
        check("dm_rdata", {32'b0, dm_rdata}, {32'b0, mon_e.data});
        check("dm_rvalid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Requester protocol: a request stays up until it is granted.
  logic p_if_req = 1'b0, p_if_gnt = 1'b0, p_dm_req = 1'b0, p_dm_gnt = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(p_if_req && !p_if_gnt && !if_req)) else $error("if_req dropped before if_gnt");
      assert (!(p_dm_req && !p_dm_gnt && !dm_req)) else $error("dm_req dropped before dm_gnt");
    end
    p_if_req <= if_req; p_if_gnt <= if_gnt;
    p_dm_req <= dm_req; p_dm_gnt <= dm_gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int       t;
    int       t0;
    int       k;
    bit       g_if;
    bit       g_dm;
    bit [7:0] exp_dm;
    bit [7:0] exp_if;

    for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
    mem[3] <= 32'hA5A5_0001;

    // Reset state
    @(negedge clk);
    check("reset_ctrl", {57'b0, if_gnt, dm_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid}, 64'd0);
    check("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // IF read of mem[3]
    t0 = cyc;
    if_req = 1'b1; if_addr = 10'd3;
    wait_gnt(1'b0, t);
    check("if_read_gnt_cycle", 64'(t), 64'(t0));
    check("if_read_mem_addr", {54'b0, mem_addr}, 64'd3);
    check("if_read_mem_we", {63'b0, mem_we}, 64'd0);
    if_q.push_back('{32'hA5A5_0001, t + 2});
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("if_read_busy_t1", {63'b0, busy}, 64'd1);
    tick();
    @(negedge clk);
    check("if_read_busy_t2", {63'b0, busy}, 64'd0);
    repeat (2) tick();

    // Contention: DM load of addr 8 beats IF fetch of addr 4
    t0 = cyc;
    if_req = 1'b1; if_addr = 10'd4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd8;
    @(negedge clk);
    check("cont_dm_gnt", {62'b0, dm_gnt, if_gnt}, 64'b10);
    check("cont_mem_addr", {54'b0, mem_addr}, 64'd8);
    dm_q.push_back('{32'h1000_0008, t0 + 2});
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    check("cont_no_gnt_rd_wait", {62'b0, dm_gnt, if_gnt}, 64'b00);
    tick();
    wait_gnt(1'b0, t);
    check("cont_if_gnt_cycle", 64'(t), 64'(t0 + 2));
    check("cont_if_mem_addr", {54'b0, mem_addr}, 64'd4);
    if_q.push_back('{32'h1000_0004, t + 2});
    tick();
    if_req = 1'b0;
    repeat (3) tick();

    // Store then load at addr 7; an if_flush during the DM load is ignored
    t0 = cyc;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd7; dm_wdata = 32'h0000_1234;
    @(negedge clk);
    check("sw_gnt", {63'b0, dm_gnt}, 64'd1);
    check("sw_mem_we", {62'b0, mem_en, mem_we}, 64'b11);
    check("sw_mem_wdata", {32'b0, mem_wdata}, 64'h1234);
    tick();
    dm_we = 1'b0;
    @(negedge clk);
    check("lw_gnt", {62'b0, dm_gnt, mem_we}, 64'b10);
    dm_q.push_back('{32'h0000_1234, t0 + 3});
    tick();
    dm_req = 1'b0; if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    repeat (3) tick();

    // Starvation: DM stores every IDLE cycle while IF fetch of addr 6 waits
    exp_dm = 8'b0100_1111;
    exp_if = 8'b0001_0000;
    k = 0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd100; dm_wdata = 32'h5000_0000;
    if_req = 1'b1; if_addr = 10'd6;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      g_dm = dm_gnt;
      g_if = if_gnt;
      check($sformatf("starve_dm_gnt_c%0d", c), {63'b0, g_dm}, {63'b0, exp_dm[c]});
      check($sformatf("starve_if_gnt_c%0d", c), {63'b0, g_if}, {63'b0, exp_if[c]});
      if (g_if) if_q.push_back('{32'h1000_0006, cyc + 2});
      tick();
      if (g_if) if_req = 1'b0;
      if (g_dm) begin
        k++;
        dm_addr  = 10'(100 + k);
        dm_wdata = 32'h5000_0000 + k;
      end
    end
    dm_req = 1'b0;
    tick();
    dm_load(10'd104, 32'h5000_0004);
    dm_load(10'd101, 32'h5000_0001);
    repeat (3) tick();

    // Squash: flush during RD_WAIT kills fetch of addr 10; the fetch of
    // addr 20 granted alongside a flush is delivered
    if_req = 1'b1; if_addr = 10'd10;
    wait_gnt(1'b0, t);
    tick();
    if_req = 1'b0; if_flush = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 10'd20;
    @(negedge clk);
    check("squash_new_gnt", {63'b0, if_gnt}, 64'd1);
    if_q.push_back('{32'h1000_0014, cyc + 2});
    tick();
    if_req = 1'b0; if_flush = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a read of addr 5
    if_req = 1'b1; if_addr = 10'd5;
    wait_gnt(1'b0, t);
    tick();
    if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {57'b0, if_gnt, dm_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid}, 64'd0);
    check("midrst_rdata", {if_rdata, dm_rdata}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("postrst_if_rdata", {32'b0, if_rdata}, 64'd0);
    tick();
    if_read(10'd5, 32'h1000_0005);
    repeat (4) tick();

    check("if_queue_drained", 64'(if_q.size()), 64'd0);
    check("dm_queue_drained", 64'(dm_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
